// File: rtl/serial_pattern_gen_if.sv
// Load port and serial output bundle for serial_pattern_gen.
// The slave modport is the generator; the master modport is the block that feeds it and watches the line.
interface serial_pattern_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W),
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len_m1;
    logic [CNT_W-1:0] rep_m1;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, pattern, len_m1, rep_m1, gap, abort,
        input  load_ready, dout, dout_valid, frame_start, busy, done
    );

    modport slave (
        input  load_valid, pattern, len_m1, rep_m1, gap, abort,
        output load_ready, dout, dout_valid, frame_start, busy, done
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: sends pattern[len_m1:0] MSB-first, (rep_m1+1) times,
// with gap idle cycles between repetitions.
//   state   | meaning
//   S_IDLE  | waiting for a load; load_ready high
//   S_SHIFT | dout carries captured pattern[idx_q]
//   S_GAP   | idle cycles between repetitions; gap_cnt_q counts down to 0
module serial_pattern_gen #(
    parameter int   PAT_W    = 8,
    parameter int   LEN_W    = $clog2(PAT_W),
    parameter int   CNT_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    serial_pattern_gen_if.slave sp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_q;
    logic [LEN_W-1:0] idx_q;
    logic [CNT_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_cnt_q;

    logic dout_q, dout_valid_q, frame_start_q, done_q;
    logic dout_d, dout_valid_d, frame_start_d, done_d;

    logic             last_bit;
    logic             last_rep;
    logic             gap_tc;
    logic [LEN_W-1:0] idx_dec;

    assign last_bit = (idx_q == '0);
    assign last_rep = (rep_q == '0);
    assign gap_tc   = (gap_cnt_q == '0);
    assign idx_dec  = idx_q - LEN_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sp.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sp.load_valid) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (last_bit) begin
                        if (last_rep)          state_d = S_IDLE;
                        else if (gap_q != '0)  state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_tc) state_d = S_SHIFT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered, so this computes what the line shows in the next cycle.
    always_comb begin
        dout_d        = IDLE_BIT;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        if (!sp.abort) begin
            case (state_q)
                S_IDLE: begin
                    if (sp.load_valid) begin
                        dout_d        = sp.pattern[sp.len_m1];
                        dout_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!last_bit) begin
                        dout_d       = pat_q[idx_dec];
                        dout_valid_d = 1'b1;
                    end else if (last_rep) begin
                        done_d = 1'b1;
                    end else if (gap_q == '0) begin
                        dout_d        = pat_q[len_q];
                        dout_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_tc) begin
                        dout_d        = pat_q[len_q];
                        dout_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q         <= '0;
            len_q         <= '0;
            gap_q         <= '0;
            idx_q         <= '0;
            rep_q         <= '0;
            gap_cnt_q     <= '0;
            dout_q        <= IDLE_BIT;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
            if (!sp.abort) begin
                case (state_q)
                    S_IDLE: begin
                        if (sp.load_valid) begin
                            pat_q <= sp.pattern;
                            len_q <= sp.len_m1;
                            rep_q <= sp.rep_m1;
                            gap_q <= sp.gap;
                            idx_q <= sp.len_m1;
                        end
                    end
                    S_SHIFT: begin
                        if (!last_bit) begin
                            idx_q <= idx_dec;
                        end else if (!last_rep) begin
                            rep_q <= rep_q - CNT_W'(1);
                            idx_q <= len_q;
                            // Loaded with gap-1 so the terminal count at 0 yields exactly gap idle cycles.
                            if (gap_q != '0) gap_cnt_q <= gap_q - GAP_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (!gap_tc) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sp.dout        = dout_q;
    assign sp.dout_valid  = dout_valid_q;
    assign sp.frame_start = frame_start_q;
    assign sp.done        = done_q;
    assign sp.load_ready  = (state_q == S_IDLE);
    assign sp.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Testbench for serial_pattern_gen: directed scenarios plus randomized bursts checked
// against a per-cycle expected trace built from the burst parameters.
module tb_serial_pattern_gen;

    localparam int   PAT_W    = 8;
    localparam int   LEN_W    = 3;
    localparam int   CNT_W    = 4;
    localparam int   GAP_W    = 4;
    localparam logic IDLE_BIT = 1'b0;

    // {load_ready, busy, done, frame_start, dout_valid, dout}
    localparam logic [5:0] IDLE_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_BIT};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) sp ();

    serial_pattern_gen #(
        .PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(IDLE_BIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sp    (sp)
    );

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    // Small detector for the 101 sequence on valid bits, as the downstream block would see it.
    logic [2:0] det_sr = 3'b000;
    int det_hits = 0;
    always @(negedge clk) begin
        if (reset) begin
            det_sr <= 3'b000;
        end else if (sp.dout_valid) begin
            det_sr <= {det_sr[1:0], sp.dout};
            if ({det_sr[1:0], sp.dout} == 3'b101) det_hits <= det_hits + 1;
        end
    end

    function automatic logic [5:0] obs_vec();
        return {sp.load_ready, sp.busy, sp.done, sp.frame_start, sp.dout_valid, sp.dout};
    endfunction

    // Expected trace from the cycle after the accept edge through the done cycle.
    task automatic build_exp(input logic [7:0] p, input int len, input int rep, input int gap);
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int k = len; k >= 0; k--)
                exp_q.push_back({1'b0, 1'b1, 1'b0, (k == len), 1'b1, p[k]});
            if (r < rep)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE_BIT});
        end
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE_BIT});
    endtask

    task automatic drive_cfg(input logic [7:0] p, input int len, input int rep, input int gap);
        sp.pattern = p;
        sp.len_m1  = LEN_W'(len);
        sp.rep_m1  = CNT_W'(rep);
        sp.gap     = GAP_W'(gap);
    endtask

    // Returns 1 ns after the accept edge, i.e. inside the cycle carrying the first bit.
    task automatic accept_load(input logic [7:0] p, input int len, input int rep, input int gap,
                               input bit keep_valid);
        @(negedge clk);
        drive_cfg(p, len, rep, gap);
        sp.load_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) sp.load_valid = 1'b0;
        build_exp(p, len, rep, gap);
    endtask

    task automatic check_stream(input string name, input int abort_at, input bit abort_with_load);
        logic [5:0] obs;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            obs = obs_vec();
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL %s cycle %0d: got rdy/busy/done/fs/vld/dout=%b expected %b",
                         name, i, obs, exp_q[i]);
            end
            if (i == abort_at) begin
                sp.abort = 1'b1;
                if (abort_with_load) sp.load_valid = 1'b1;
                @(posedge clk);
                #1;
                sp.abort = 1'b0;
                obs = obs_vec();
                checks++;
                if (obs !== IDLE_VEC) begin
                    failures++;
                    $display("FAIL %s after_abort: got %b expected %b", name, obs, IDLE_VEC);
                end
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        repeat (2) @(posedge clk);
        #1;
        obs = obs_vec();
        checks++;
        if (obs !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_hold: got %b expected %b", obs, IDLE_VEC);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        obs = obs_vec();
        checks++;
        if (obs !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_release: got %b expected %b", obs, IDLE_VEC);
        end
    endtask

    task automatic test_basic(input string name);
        int h0;
        h0 = det_hits;
        accept_load(8'h05, 2, 0, 0, 1'b0);
        check_stream(name, -1, 1'b0);
        checks++;
        if (det_hits - h0 != 1) begin
            failures++;
            $display("FAIL %s detector_hits: got %0d expected 1", name, det_hits - h0);
        end
    endtask

    task automatic test_gap();
        accept_load(8'hA5, 7, 2, 3, 1'b0);
        check_stream("gap3", -1, 1'b0);
    endtask

    task automatic test_contiguous();
        accept_load(8'hC3, 7, 1, 0, 1'b0);
        check_stream("contig", -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] p2;
        p2 = 8'($urandom);
        accept_load(8'h01, 0, 15, 0, 1'b1);
        drive_cfg(p2, 3, 1, 2);
        check_stream("b2b_first", -1, 1'b0);
        @(posedge clk);
        #1;
        sp.load_valid = 1'b0;
        build_exp(p2, 3, 1, 2);
        check_stream("b2b_second", -1, 1'b0);
    endtask

    task automatic test_abort();
        logic [7:0] p1, p2;
        p1 = 8'($urandom);
        p2 = 8'($urandom);
        accept_load(p1, 7, 0, 0, 1'b0);
        drive_cfg(p2, 7, 1, 1);
        check_stream("abort", 3, 1'b1);
        @(posedge clk);
        #1;
        sp.load_valid = 1'b0;
        build_exp(p2, 7, 1, 1);
        check_stream("abort_reload", -1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] p;
        int len, rep, gap, ab;
        for (int n = 0; n < 24; n++) begin
            p   = 8'($urandom);
            len = $urandom_range(0, 7);
            rep = $urandom_range(0, 15);
            gap = $urandom_range(0, 15);
            accept_load(p, len, rep, gap, 1'b0);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, exp_q.size() - 2) : -1;
            check_stream($sformatf("rand%0d", n), ab, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs;
        accept_load(8'h3C, 7, 3, 2, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        obs = obs_vec();
        checks++;
        if (obs !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_mid: got %b expected %b", obs, IDLE_VEC);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_basic("basic_after_reset");
    endtask

    initial begin
        sp.load_valid = 1'b0;
        sp.abort      = 1'b0;
        drive_cfg(8'h00, 0, 0, 0);
        test_reset();
        test_basic("basic");
        test_gap();
        test_contiguous();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
